// File: rtl/m_mem_arbiter.sv
// rtl/m_mem_arbiter.sv - single-port memory arbiter between instruction fetch and data ports
module m_mem_arbiter #(
  parameter int ADDR_W     = 12,
  parameter int DATA_W     = 32,
  parameter int STARVE_MAX = 3,
  parameter int CNT_W      = 32
) (
  input  logic              w_clk,
  input  logic              w_rst,
  input  logic              w_i_req,
  input  logic [ADDR_W-1:0] w_i_addr,
  output logic              w_i_gnt,
  output logic              r_i_vld,
  output logic [DATA_W-1:0] w_i_rdata,
  input  logic              w_d_req,
  input  logic              w_d_we,
  input  logic [ADDR_W-1:0] w_d_addr,
  input  logic [DATA_W-1:0] w_d_din,
  output logic              w_d_gnt,
  output logic              r_d_vld,
  output logic [DATA_W-1:0] w_d_rdata,
  output logic [ADDR_W-1:0] w_m_addr,
  output logic              w_m_we,
  output logic [DATA_W-1:0] w_m_din,
  input  logic [DATA_W-1:0] w_m_dout,
  output logic [CNT_W-1:0]  r_conf_cnt,
  output logic [CNT_W-1:0]  r_istall_cnt
);

  // Priority mode: data wins until IF has lost STARVE_MAX times in a row
  typedef enum logic {D_PRI, I_PRI} prio_e;

  localparam logic [3:0]       LP_MAX = 4'(STARVE_MAX);
  localparam logic [CNT_W-1:0] LP_ONE = CNT_W'(1);

  logic [3:0] r_starve;
  prio_e      w_mode;

  assign w_mode = (r_starve == LP_MAX) ? I_PRI : D_PRI;

  // Both read ports see the memory's registered output directly
  assign w_i_rdata = w_m_dout;
  assign w_d_rdata = w_m_dout;

  // Grant selection and memory drive; nothing is granted while in reset
  always_comb begin
    w_i_gnt  = 1'b0;
    w_d_gnt  = 1'b0;
    w_m_addr = '0;
    w_m_we   = 1'b0;
    w_m_din  = '0;
    if (!w_rst) begin
      if (w_i_req && (!w_d_req || (w_mode == I_PRI))) begin
        w_i_gnt  = 1'b1;
        w_m_addr = w_i_addr;
      end else if (w_d_req) begin
        w_d_gnt  = 1'b1;
        w_m_addr = w_d_addr;
        w_m_we   = w_d_we;
        w_m_din  = w_d_din;
      end
    end
  end

  // Starvation tracking, read-valid flags and saturating contention counters
  always_ff @(posedge w_clk) begin
    if (w_rst) begin
      r_starve     <= 4'd0;
      r_i_vld      <= 1'b0;
      r_d_vld      <= 1'b0;
      r_conf_cnt   <= '0;
      r_istall_cnt <= '0;
    end else begin
      r_i_vld <= w_i_gnt;
      r_d_vld <= w_d_gnt & ~w_d_we;
      if (w_i_req && !w_i_gnt) begin
        r_starve <= (r_starve == LP_MAX) ? LP_MAX : r_starve + 4'd1;
        if (r_istall_cnt != '1) r_istall_cnt <= r_istall_cnt + LP_ONE;
      end else begin
        r_starve <= 4'd0;
      end
      if (w_i_req && w_d_req && (r_conf_cnt != '1)) r_conf_cnt <= r_conf_cnt + LP_ONE;
    end
  end

endmodule

// File: tb/tb_m_mem_arbiter.sv
// tb/tb_m_mem_arbiter.sv - scoreboard bench for m_mem_arbiter with behavioural memory and reference model
module tb_m_mem_arbiter;

  localparam int SMAX = 3;

  logic        clk;
  logic        rst;
  logic        i_req;
  logic [11:0] i_addr;
  logic        i_gnt;
  logic        i_vld;
  logic [31:0] i_rdata;
  logic        d_req;
  logic        d_we;
  logic [11:0] d_addr;
  logic [31:0] d_din;
  logic        d_gnt;
  logic        d_vld;
  logic [31:0] d_rdata;
  logic [11:0] m_addr;
  logic        m_we;
  logic [31:0] m_din;
  logic [31:0] m_dout;
  logic [31:0] conf_cnt;
  logic [31:0] istall_cnt;

  m_mem_arbiter #(.ADDR_W(12), .DATA_W(32), .STARVE_MAX(SMAX), .CNT_W(32)) dut (
    .w_clk(clk), .w_rst(rst),
    .w_i_req(i_req), .w_i_addr(i_addr), .w_i_gnt(i_gnt), .r_i_vld(i_vld), .w_i_rdata(i_rdata),
    .w_d_req(d_req), .w_d_we(d_we), .w_d_addr(d_addr), .w_d_din(d_din), .w_d_gnt(d_gnt),
    .r_d_vld(d_vld), .w_d_rdata(d_rdata),
    .w_m_addr(m_addr), .w_m_we(m_we), .w_m_din(m_din), .w_m_dout(m_dout),
    .r_conf_cnt(conf_cnt), .r_istall_cnt(istall_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Environment memory: registered read, write on edge
  logic [31:0] mem [4096];
  always @(posedge clk) begin
    if (m_we) mem[m_addr] <= m_din;
    m_dout <= mem[m_addr];
  end

  // Reference model state
  logic [31:0] ref_mem [4096];
  int starve_m, conf_m, istall_m;
  int cyc;
  int n_checks, n_pass;
  bit mon_en, seen_reset;

  typedef struct {
    int          due;
    logic [31:0] data;
  } rsp_t;
  rsp_t i_q[$];
  rsp_t d_q[$];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    else n_pass++;
  endtask

  // Monitor: pops expected read data whenever a valid appears, flags spurious or missing valids
  always @(negedge clk) begin
    if (mon_en) begin
      if (i_vld === 1'b1) begin
        if (i_q.size() > 0 && i_q[0].due == cyc) begin
          chk("i_rdata", {32'h0, i_rdata}, {32'h0, i_q[0].data});
          void'(i_q.pop_front());
        end else begin
          n_checks++;
          $display("FAIL i_vld_spurious: got 1 expected 0 (cycle %0d)", cyc);
        end
      end else if (i_q.size() > 0 && i_q[0].due <= cyc) begin
        n_checks++;
        $display("FAIL i_vld_missing: got %b expected 1 (cycle %0d)", i_vld, cyc);
        void'(i_q.pop_front());
      end
      if (d_vld === 1'b1) begin
        if (d_q.size() > 0 && d_q[0].due == cyc) begin
          chk("d_rdata", {32'h0, d_rdata}, {32'h0, d_q[0].data});
          void'(d_q.pop_front());
        end else begin
          n_checks++;
          $display("FAIL d_vld_spurious: got 1 expected 0 (cycle %0d)", cyc);
        end
      end else if (d_q.size() > 0 && d_q[0].due <= cyc) begin
        n_checks++;
        $display("FAIL d_vld_missing: got %b expected 1 (cycle %0d)", d_vld, cyc);
        void'(d_q.pop_front());
      end
    end
  end

  bit last_gi, last_gd;

  // One clock cycle of stimulus, grant checking and model update
  task automatic step(input logic ir, input logic [11:0] ia, input logic dr, input logic dwe,
                      input logic [11:0] da, input logic [31:0] dd, input logic rs);
    bit eg_i, eg_d;
    @(posedge clk);
    #1;
    rst = rs; i_req = ir; i_addr = ia; d_req = dr; d_we = dwe; d_addr = da; d_din = dd;
    #1;
    if (rs) begin
      eg_i = 0; eg_d = 0;
    end else begin
      eg_d = dr && !(ir && starve_m == SMAX);
      eg_i = ir && !eg_d;
    end
    chk("i_gnt", {63'h0, i_gnt}, {63'h0, eg_i});
    chk("d_gnt", {63'h0, d_gnt}, {63'h0, eg_d});
    chk("m_we", {63'h0, m_we}, {63'h0, eg_d && dwe});
    chk("m_addr", {52'h0, m_addr}, {52'h0, eg_i ? ia : (eg_d ? da : 12'h0)});
    if (eg_d && dwe) chk("m_din", {32'h0, m_din}, {32'h0, dd});
    if (seen_reset) begin
      chk("conf_cnt", {32'h0, conf_cnt}, 64'(conf_m));
      chk("istall_cnt", {32'h0, istall_cnt}, 64'(istall_m));
      chk("starve", 64'(dut.r_starve), 64'(starve_m));
    end
    if (eg_i) i_q.push_back('{due: cyc + 1, data: ref_mem[ia]});
    if (eg_d && !dwe) d_q.push_back('{due: cyc + 1, data: ref_mem[da]});
    if (eg_d && dwe) ref_mem[da] = dd;
    if (rs) begin
      starve_m = 0; conf_m = 0; istall_m = 0;
      seen_reset = 1;
    end else begin
      if (ir && dr) conf_m++;
      if (ir && !eg_i) begin
        istall_m++;
        starve_m = (starve_m + 1 > SMAX) ? SMAX : starve_m + 1;
      end else begin
        starve_m = 0;
      end
    end
    last_gi = eg_i; last_gd = eg_d;
  endtask

  logic [1:0]  seq_got [8];
  logic [1:0]  seq_exp [8];
  bit          ip, dp, dwe_p;
  logic [11:0] ia_p, da_p;
  logic [31:0] dd_p;

  initial begin
    n_checks = 0; n_pass = 0; cyc = 0; mon_en = 0; seen_reset = 0;
    starve_m = 0; conf_m = 0; istall_m = 0;
    rst = 1; i_req = 0; i_addr = 0; d_req = 0; d_we = 0; d_addr = 0; d_din = 0;
    for (int i = 0; i < 4096; i++) begin
      mem[i] = 32'(i) * 32'h9e37_79b9 ^ 32'h5a5a_0000;
      ref_mem[i] = 32'(i) * 32'h9e37_79b9 ^ 32'h5a5a_0000;
    end
    mem[5] = 32'h0000_1234;
    ref_mem[5] = 32'h0000_1234;

    // Reset with both requests high
    step(1, 12'd1, 1, 0, 12'd2, 0, 1);
    step(1, 12'd1, 1, 0, 12'd2, 0, 1);
    mon_en = 1;

    // IF only
    step(1, 12'd5, 0, 0, 12'd0, 0, 0);
    step(0, 12'd0, 0, 0, 12'd0, 0, 0);

    // Contention: expect D,D,D,I,D,D,D,I
    step(0, 0, 0, 0, 0, 0, 1);
    for (int k = 0; k < 8; k++) begin
      step(1, 12'(k), 1, 0, 12'(k + 20), 0, 0);
      seq_got[k] = {i_gnt, d_gnt};
      seq_exp[k] = (k % 4 == 3) ? 2'b10 : 2'b01;
    end
    for (int k = 0; k < 8; k++) chk("contention_seq", 64'(seq_got[k]), 64'(seq_exp[k]));
    step(0, 0, 0, 0, 0, 0, 0);
    chk("conf_after_8", {32'h0, conf_cnt}, 64'd8);
    chk("istall_after_8", {32'h0, istall_cnt}, 64'd6);

    // Store then fetch the same address
    step(0, 0, 1, 1, 12'd7, 32'hdead_beef, 0);
    step(1, 12'd7, 0, 0, 12'd0, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0);

    // Reset mid-stream with r_starve at 2, then contention resumes
    step(1, 12'd3, 1, 0, 12'd4, 0, 0);
    step(1, 12'd3, 1, 0, 12'd4, 0, 0);
    step(1, 12'd3, 1, 0, 12'd4, 0, 1);
    for (int k = 0; k < 4; k++) step(1, 12'd3, 1, 0, 12'd4, 0, 0);

    // Idle
    for (int k = 0; k < 4; k++) step(0, 0, 0, 0, 0, 0, 0);

    // Randomized traffic with held requests
    ip = 0; dp = 0; ia_p = 0; da_p = 0; dd_p = 0; dwe_p = 0;
    for (int n = 0; n < 600; n++) begin
      if (!ip && $urandom_range(0, 2) != 0) begin
        ip = 1; ia_p = 12'($urandom_range(0, 15));
      end
      if (!dp && $urandom_range(0, 2) != 0) begin
        dp = 1; da_p = 12'($urandom_range(0, 15));
        dwe_p = $urandom_range(0, 2) == 0; dd_p = $urandom;
      end
      if (ip && $urandom_range(0, 31) == 0) ip = 0;
      if (dp && $urandom_range(0, 31) == 0) dp = 0;
      if ($urandom_range(0, 63) == 0) begin
        step(ip, ia_p, dp, dwe_p, da_p, dd_p, 1);
        ip = 0; dp = 0;
      end else begin
        step(ip, ia_p, dp, dwe_p, da_p, dd_p, 0);
        if (last_gi) ip = 0;
        if (last_gd) dp = 0;
      end
    end

    for (int k = 0; k < 3; k++) step(0, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    chk("i_q_drained", 64'(i_q.size()), 64'd0);
    chk("d_q_drained", 64'(d_q.size()), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
